// File: rtl/console_pkg.sv
// Shared definitions for the console USB scheduler: one-hot state codes and
// default timing/index parameters.
package console_pkg;

  localparam int unsigned ST_W = 7;

  localparam logic [ST_W-1:0] ST_IDLE        = 7'b000_0001;
  localparam logic [ST_W-1:0] ST_CONF_REQ    = 7'b000_0010;
  localparam logic [ST_W-1:0] ST_CONF_ACK    = 7'b000_0100;
  localparam logic [ST_W-1:0] ST_PERIOD_WAIT = 7'b000_1000;
  localparam logic [ST_W-1:0] ST_CONV_REQ    = 7'b001_0000;
  localparam logic [ST_W-1:0] ST_CONV_ACK    = 7'b010_0000;
  localparam logic [ST_W-1:0] ST_ERROR       = 7'b100_0000;

  typedef enum logic [ST_W-1:0] {
    S_IDLE        = ST_IDLE,
    S_CONF_REQ    = ST_CONF_REQ,
    S_CONF_ACK    = ST_CONF_ACK,
    S_PERIOD_WAIT = ST_PERIOD_WAIT,
    S_CONV_REQ    = ST_CONV_REQ,
    S_CONV_ACK    = ST_CONV_ACK,
    S_ERROR       = ST_ERROR
  } state_e;

  localparam logic [31:0] DEF_CONV_PERIOD = 32'd50_000;
  localparam logic [31:0] DEF_TIMEOUT     = 32'd1_000_000;
  localparam logic [3:0]  DEF_IDX_NUM     = 4'h6;

endpackage

// File: rtl/console_sched_timer.sv
// Free-running 32-bit cycle timer with synchronous clear and two terminal
// compares: end of the inter-conversion period and handshake timeout.
module console_sched_timer
  import console_pkg::*;
#(
  parameter logic [31:0] CONV_PERIOD = DEF_CONV_PERIOD,
  parameter logic [31:0] TIMEOUT     = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic period_hit,
  output logic timeout_hit
);

  logic [31:0] cnt_q, cnt_d;

  // Clear wins; otherwise count up (wraps harmlessly while parked in IDLE/ERROR)
  always_comb begin
    cnt_d = clr ? 32'd0 : cnt_q + 32'd1;
  end

  // Timer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 32'd0;
    else     cnt_q <= cnt_d;
  end

  assign period_hit  = (cnt_q == CONV_PERIOD - 32'd1);
  assign timeout_hit = (cnt_q == TIMEOUT - 32'd1);

endmodule

// File: rtl/console_usb_sched.sv
// Sequencer for the console USB core: one configuration handshake after
// enable, then periodic conversion handshakes with a rotating data index,
// a wrapping completion count and a handshake timeout trap.
module console_usb_sched
  import console_pkg::*;
#(
  parameter logic [31:0] CONV_PERIOD = DEF_CONV_PERIOD,
  parameter logic [31:0] TIMEOUT     = DEF_TIMEOUT,
  parameter logic [3:0]  IDX_NUM     = DEF_IDX_NUM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        conf_req,
  output logic        fs_conf,
  input  logic        fd_conf,
  output logic        fs_conv,
  input  logic        fd_conv,
  output logic [3:0]  data_idx,
  output logic [15:0] conv_cnt,
  output logic        busy,
  output logic        err_timeout
);

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        period_hit, timeout_hit, tmr_clr, pending;

  // A conf_req arriving in the very cycle the period expires must still win,
  // so the live pulse is folded in alongside the stored flag.
  assign pending = pend_q | conf_req;
  assign tmr_clr = (state_d != state_q);

  console_sched_timer #(
    .CONV_PERIOD (CONV_PERIOD),
    .TIMEOUT     (TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clr         (tmr_clr),
    .period_hit  (period_hit),
    .timeout_hit (timeout_hit)
  );

  // Next-state logic; done edges take priority over a coincident timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:        if (enable) state_d = S_CONF_REQ;
      S_CONF_REQ:    if (fd_conf) state_d = S_CONF_ACK;
                     else if (timeout_hit) state_d = S_ERROR;
      S_CONF_ACK:    if (!fd_conf) state_d = S_PERIOD_WAIT;
                     else if (timeout_hit) state_d = S_ERROR;
      S_PERIOD_WAIT: if (!enable) state_d = S_IDLE;
                     else if (pending) state_d = S_CONF_REQ;
                     else if (period_hit) state_d = S_CONV_REQ;
      S_CONV_REQ:    if (fd_conv) state_d = S_CONV_ACK;
                     else if (timeout_hit) state_d = S_ERROR;
      S_CONV_ACK:    if (!fd_conv) state_d = S_PERIOD_WAIT;
                     else if (timeout_hit) state_d = S_ERROR;
      S_ERROR:       if (!enable) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Pending flag, data index and conversion count updates
  always_comb begin
    pend_d = pending;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    // entering CONF_REQ consumes the request, including one arriving this cycle
    if (state_d == S_CONF_REQ && state_q != S_CONF_REQ) pend_d = 1'b0;
    if (state_q == S_IDLE && state_d != S_IDLE) idx_d = 4'd0;
    if (state_q == S_CONV_ACK && state_d == S_PERIOD_WAIT) begin
      idx_d = (idx_q == IDX_NUM - 4'd1) ? 4'd0 : idx_q + 4'd1;
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      idx_q   <= 4'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from the registered state
  assign fs_conf     = (state_q == S_CONF_REQ);
  assign fs_conv     = (state_q == S_CONV_REQ);
  assign busy        = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign err_timeout = (state_q == S_ERROR);
  assign data_idx    = idx_q;
  assign conv_cnt    = cnt_q;

endmodule

// File: doc/console_usb_sched.md
# console_usb_sched

Sequencing controller for the console USB core. It owns the `fs_conf`/`fd_conf` and `fs_conv`/`fd_conv` request/done handshakes.
- After enable, it issues one configuration transaction, then periodic conversion transactions.
- It tracks the rotating data index fed to the core and counts completed conversions.
- It flags a handshake timeout if the core never answers.

It sits between console top-level control and the USB core; it is the only driver of the core's conf/conv request inputs.

## Interface
Parameters:
- CONV_PERIOD, 32'd50_000: idle cycles in PERIOD_WAIT between conversions.
- TIMEOUT, 32'd1_000_000: max cycles waiting for a done edge before ERROR.
- IDX_NUM, 4'h6: data-index modulus.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  level; run scheduler
- conf_req  in  1  single-cycle pulse; request re-configuration
- fs_conf  out  1  conf request to core
- fd_conf  in  1  conf done from core
- fs_conv  out  1  conv request to core
- fd_conv  in  1  conv done from core
- data_idx  out  4  index presented to core, range 0..IDX_NUM-1
- conv_cnt  out  16  completed conversions, wraps
- busy  out  1  high in any state except IDLE and ERROR
- err_timeout  out  1  high in ERROR

## Operation
- Reset value of every output is 0. Internal timer and conf-pending flag are also reset to 0.
- State machine, one-hot, registered: IDLE, CONF_REQ, CONF_ACK, PERIOD_WAIT, CONV_REQ, CONV_ACK, ERROR.
  - IDLE: enable=1 → CONF_REQ.
  - CONF_REQ: fs_conf=1. fd_conf=1 → CONF_ACK. timer==TIMEOUT-1 → ERROR.
  - CONF_ACK: fs_conf=0. fd_conf=0 → PERIOD_WAIT. Timeout applies as in CONF_REQ.
  - PERIOD_WAIT, priority order:
    1. enable=0 → IDLE.
    2. pending=1 → CONF_REQ.
    3. timer==CONV_PERIOD-1 → CONV_REQ.
  - CONV_REQ: fs_conv=1. fd_conv=1 → CONV_ACK. Timeout → ERROR.
  - CONV_ACK: fs_conv=0. fd_conv=0 → PERIOD_WAIT. Timeout → ERROR.
    - On this exit: data_idx ← (data_idx==IDX_NUM-1) ? 0 : data_idx+1.
    - On this exit: conv_cnt ← conv_cnt+1, modulo 2^16.
  - ERROR: fs_conf=fs_conv=0. enable=0 → IDLE.
- fs_conf and fs_conv are never high together.
- Timer: 32-bit. Cleared on every state change, otherwise increments by 1.
- Conf-pending flag:
  - Set by conf_req in any state.
  - Cleared on entry to CONF_REQ.
  - A conf_req arriving during CONF_REQ/CONF_ACK survives and causes a second configuration.
- Leaving IDLE clears err_timeout and data_idx to 0. conv_cnt is kept; it clears only on rst.
- enable falling mid-handshake: the handshake completes normally. The IDLE return happens from PERIOD_WAIT.
- Simultaneous pending conf and period expiry: conf wins, and the timer restarts after conf.
- rst mid-handshake: immediate return to IDLE, with fs_* low in the same cycle the reset asserts.

## Timing
- All outputs are decoded from registered state, so they are glitch-free at cycle granularity.
- enable sampled high at edge N → fs_conf high from N+1.
- fd_conf sampled high at edge M → fs_conf low from M+1. fd_conf sampled low at edge K → PERIOD_WAIT from K+1.
- PERIOD_WAIT entered at cycle t → fs_conv high at t+CONV_PERIOD when uninterrupted.
- Conversion period end-to-end = CONV_PERIOD + core handshake latency + 2 cycles (REQ→ACK, ACK→WAIT).
- ERROR is entered exactly TIMEOUT cycles after the waiting state is entered.
- data_idx and conv_cnt update on the CONV_ACK→PERIOD_WAIT edge. data_idx is stable throughout every CONV_REQ.

## Structure
- Shared package console_pkg holds:
  - State one-hot localparams (7 bits).
  - Default IDX_NUM, CONV_PERIOD and TIMEOUT values.
- One natural sub-module, console_sched_timer:
  - 32-bit counter with synchronous clear.
  - Two terminal-compare outputs: period_hit and timeout_hit.
  - Instantiated once.

## Test plan
Bench parameters: CONV_PERIOD=8, TIMEOUT=16, IDX_NUM=6. The core model answers the done signal 3 cycles after the request and drops it 1 cycle after the request falls.
- Reset, then enable=1 → fs_conf high 1 cycle later. After the conf handshake, fs_conv first rises 8 cycles after PERIOD_WAIT entry. busy=1 throughout.
- 7 conversions → data_idx sequence 0,1,2,3,4,5,0,1; conv_cnt=7. fs_conf and fs_conv are never both high.
- Core model never raises fd_conv → ERROR exactly 16 cycles after CONV_REQ entry; err_timeout=1, busy=0, fs_conv=0. Dropping enable → IDLE. Re-enabling clears err_timeout and data_idx; conv_cnt is retained.
- conf_req pulsed on the same cycle the period expires → CONF_REQ is taken, not CONV_REQ; conv follows 8 cycles after the conf completes. A conf_req pulsed during CONF_ACK → a second conf handshake immediately after.
- enable dropped during CONV_REQ → the handshake completes, conv_cnt increments, then IDLE one cycle after PERIOD_WAIT entry.
- rst asserted mid-CONV_REQ → fs_conv=0 asynchronously. All outputs are 0 after release.
